// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if
//   Bundles the request/response and memory-port signals of the instruction
//   memory arbiter. Signal names keep the _i/_o suffixes as seen from the
//   arbiter, so the slave modport is the arbiter's view and the master modport
//   is the environment (fetch stage, loader and memory).
//
//   Fetch port   : f_req_i, f_addr_i -> f_gnt_o, f_rvalid_o, f_rdata_o
//   Loader port  : l_req_i, l_we_i, l_addr_i, l_wdata_i, l_lock_i
//                  -> l_gnt_o, l_rvalid_o, l_rdata_o
//   Shared       : misalign_o (accompanies either rvalid)
//   Memory port  : m_addr_o, m_we_o, m_wdata_o <- m_rdata_i
interface imem_arbiter_if #(
  parameter int IMEM_W = 14
);
  logic              f_req_i;
  logic [IMEM_W-1:0] f_addr_i;
  logic              f_gnt_o;
  logic              f_rvalid_o;
  logic [31:0]       f_rdata_o;

  logic              l_req_i;
  logic              l_we_i;
  logic [IMEM_W-1:0] l_addr_i;
  logic [31:0]       l_wdata_i;
  logic              l_lock_i;
  logic              l_gnt_o;
  logic              l_rvalid_o;
  logic [31:0]       l_rdata_o;

  logic              misalign_o;

  logic [IMEM_W-1:0] m_addr_o;
  logic              m_we_o;
  logic [31:0]       m_wdata_o;
  logic [31:0]       m_rdata_i;

  modport slave (
    input  f_req_i, f_addr_i,
    input  l_req_i, l_we_i, l_addr_i, l_wdata_i, l_lock_i,
    input  m_rdata_i,
    output f_gnt_o, f_rvalid_o, f_rdata_o,
    output l_gnt_o, l_rvalid_o, l_rdata_o,
    output misalign_o,
    output m_addr_o, m_we_o, m_wdata_o
  );

  modport master (
    output f_req_i, f_addr_i,
    output l_req_i, l_we_i, l_addr_i, l_wdata_i, l_lock_i,
    output m_rdata_i,
    input  f_gnt_o, f_rvalid_o, f_rdata_o,
    input  l_gnt_o, l_rvalid_o, l_rdata_o,
    input  misalign_o,
    input  m_addr_o, m_we_o, m_wdata_o
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Shares a single-port, combinationally-read instruction memory between the
//   core fetch port (read only) and the loader/debug port (read or write).
//   One access per cycle; grant is combinational in the request cycle and the
//   response (rvalid/rdata/misalign) is registered and presented one cycle
//   after the grant to the requester that owned it.
//
//   Ports:
//     clk_i  - clock, rising edge
//     rst_i  - asynchronous active-high reset; forces all grants and m_we low
//     bus    - imem_arbiter_if.slave (fetch, loader and memory signals)
//
//   Configuration macro IMEM_ARB_RR_EN:
//     undefined - fixed priority, loader first, with a fetch starvation guard
//                 that forces a fetch grant after STARVE_MAX denied cycles
//     defined   - round-robin on contention; a locked loader may keep the
//                 grant for at most STARVE_MAX consecutive cycles while fetch
//                 is waiting
module imem_arbiter #(
  parameter int IMEM_W     = 14,
  parameter int STARVE_MAX = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  imem_arbiter_if.slave bus
);

  typedef enum logic {
    OWN_FETCH  = 1'b0,
    OWN_LOADER = 1'b1
  } owner_e;

  localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

  logic              fGnt;
  logic              lGnt;
  logic              contended;
  logic              lockHold;
  logic [IMEM_W-1:0] selAddr;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lGntPrev_q, lGntPrev_d;
  logic              rspValid_q, rspValid_d;
  owner_e            rspOwner_q, rspOwner_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       fRdata_q, fRdata_d;
  logic [31:0]       lRdata_q, lRdata_d;

`ifdef IMEM_ARB_RR_EN
  owner_e            lastGnt_q, lastGnt_d;
`endif

  // Grant selection. cnt_q is the fetch starvation count in fixed-priority
  // mode and the length of the current loader run against a waiting fetch
  // in round-robin mode.
  always_comb begin
    fGnt      = 1'b0;
    lGnt      = 1'b0;
    cnt_d     = '0;
    contended = bus.f_req_i && bus.l_req_i;
`ifdef IMEM_ARB_RR_EN
    lockHold  = lGntPrev_q && bus.l_req_i && bus.l_lock_i && (cnt_q < CNT_MAX);
    if (!rst_i) begin
      if (contended) begin
        if (lockHold)                    lGnt = 1'b1;
        else if (lastGnt_q == OWN_LOADER) fGnt = 1'b1;
        else                             lGnt = 1'b1;
      end else begin
        fGnt = bus.f_req_i;
        lGnt = bus.l_req_i;
      end
    end
    if (lGnt && bus.f_req_i) begin
      cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    end
`else
    lockHold  = lGntPrev_q && bus.l_req_i && bus.l_lock_i;
    if (!rst_i) begin
      // A due forced fetch beats both the lock and the loader's priority.
      if (contended && (cnt_q >= CNT_MAX)) fGnt = 1'b1;
      else if (lockHold)                   lGnt = 1'b1;
      else if (bus.l_req_i)                lGnt = 1'b1;
      else if (bus.f_req_i)                fGnt = 1'b1;
    end
    if (bus.f_req_i && !fGnt) begin
      cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    end
`endif
  end

  // Memory port follows the granted requester; bits [1:0] are dropped since
  // the memory is word organised.
  always_comb begin
    selAddr       = lGnt ? bus.l_addr_i : bus.f_addr_i;
    bus.m_addr_o  = {selAddr[IMEM_W-1:2], 2'b00};
    bus.m_we_o    = lGnt && bus.l_we_i;
    bus.m_wdata_o = lGnt ? bus.l_wdata_i : 32'h0;
    bus.f_gnt_o   = fGnt;
    bus.l_gnt_o   = lGnt;
  end

  // Response capture. Each port keeps its own rdata so the idle port's
  // output holds its last value.
  always_comb begin
    rspValid_d = fGnt || lGnt;
    rspOwner_d = rspOwner_q;
    misalign_d = misalign_q;
    fRdata_d   = fRdata_q;
    lRdata_d   = lRdata_q;
    lGntPrev_d = lGnt;
    if (fGnt || lGnt) begin
      rspOwner_d = lGnt ? OWN_LOADER : OWN_FETCH;
      misalign_d = |selAddr[1:0];
    end
    if (fGnt) fRdata_d = bus.m_rdata_i;
    if (lGnt) lRdata_d = bus.l_we_i ? 32'h0 : bus.m_rdata_i;
  end

`ifdef IMEM_ARB_RR_EN
  always_comb begin
    lastGnt_d = lastGnt_q;
    if (fGnt) lastGnt_d = OWN_FETCH;
    if (lGnt) lastGnt_d = OWN_LOADER;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lastGnt_q <= OWN_FETCH;
    else       lastGnt_q <= lastGnt_d;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      lGntPrev_q <= 1'b0;
      rspValid_q <= 1'b0;
      rspOwner_q <= OWN_FETCH;
      misalign_q <= 1'b0;
      fRdata_q   <= 32'h0;
      lRdata_q   <= 32'h0;
    end else begin
      cnt_q      <= cnt_d;
      lGntPrev_q <= lGntPrev_d;
      rspValid_q <= rspValid_d;
      rspOwner_q <= rspOwner_d;
      misalign_q <= misalign_d;
      fRdata_q   <= fRdata_d;
      lRdata_q   <= lRdata_d;
    end
  end

  assign bus.f_rvalid_o = rspValid_q && (rspOwner_q == OWN_FETCH);
  assign bus.l_rvalid_o = rspValid_q && (rspOwner_q == OWN_LOADER);
  assign bus.f_rdata_o  = fRdata_q;
  assign bus.l_rdata_o  = lRdata_q;
  assign bus.misalign_o = rspValid_q && misalign_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter
//   Directed bench for imem_arbiter. Stimulus drives one request pattern per
//   cycle, checks the combinational grant/memory-port outputs, and pushes the
//   expected response into a queue; a separate monitor pops and compares
//   whenever a response cycle comes around. Memory words are preloaded with
//   0xA5A5_0000 | word_index.
module tb_imem_arbiter;

  localparam int IMEM_W     = 14;
  localparam int STARVE_MAX = 8;
  localparam int WORDS      = 1 << (IMEM_W - 2);

  typedef struct {
    logic        owner;
    logic [31:0] data;
    logic        mis;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int   vectors     = 0;
  int   miscompares = 0;
  rsp_t expQ[$];

  logic [31:0] mem [0:WORDS-1];
  logic [31:0] lastF;
  logic [31:0] lastL;
  rsp_t        monRsp;

  imem_arbiter_if #(.IMEM_W(IMEM_W)) bus ();

  imem_arbiter #(
    .IMEM_W    (IMEM_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Single-port memory: combinational read, write at the rising edge.
  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 32'hA5A5_0000 | i;
  end

  always @(posedge clk) begin
    if (bus.m_we_o) mem[bus.m_addr_o[IMEM_W-1:2]] <= bus.m_wdata_o;
  end

  assign bus.m_rdata_i = mem[bus.m_addr_o[IMEM_W-1:2]];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One cycle of requests: drive after the falling edge, check grants, queue
  // the response expected in the following cycle.
  task automatic applyStimulus(
    input logic              fReq,
    input logic [IMEM_W-1:0] fAddr,
    input logic              lReq,
    input logic              lWe,
    input logic [IMEM_W-1:0] lAddr,
    input logic [31:0]       lWdata,
    input logic              lLock,
    input logic              expF,
    input logic              expL,
    input logic [31:0]       expData,
    input logic              expMis
  );
    rsp_t r;
    logic [IMEM_W-1:0] expAddr;
    @(negedge clk);
    bus.f_req_i   = fReq;
    bus.f_addr_i  = fAddr;
    bus.l_req_i   = lReq;
    bus.l_we_i    = lWe;
    bus.l_addr_i  = lAddr;
    bus.l_wdata_i = lWdata;
    bus.l_lock_i  = lLock;
    #1;
    checkOutput("f_gnt", bus.f_gnt_o, expF);
    checkOutput("l_gnt", bus.l_gnt_o, expL);
    checkOutput("m_we", bus.m_we_o, expL & lWe);
    if (expL || expF) begin
      expAddr = expL ? lAddr : fAddr;
      expAddr[1:0] = 2'b00;
      checkOutput("m_addr", bus.m_addr_o, expAddr);
      if (expL && lWe) checkOutput("m_wdata", bus.m_wdata_o, lWdata);
      r.owner = expL;
      r.data  = expData;
      r.mis   = expMis;
      expQ.push_back(r);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Monitor: one slot per cycle, just after the rising edge.
  initial begin
    lastF = 32'h0;
    lastL = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        lastF = 32'h0;
        lastL = 32'h0;
      end
      if (expQ.size() == 0) begin
        checkOutput("idle_rvalid", {30'h0, bus.f_rvalid_o, bus.l_rvalid_o}, 32'h0);
        checkOutput("idle_misalign", bus.misalign_o, 1'b0);
      end else begin
        monRsp = expQ.pop_front();
        checkOutput("f_rvalid", bus.f_rvalid_o, !monRsp.owner);
        checkOutput("l_rvalid", bus.l_rvalid_o, monRsp.owner);
        checkOutput("misalign", bus.misalign_o, monRsp.mis);
        if (monRsp.owner) begin
          checkOutput("l_rdata", bus.l_rdata_o, monRsp.data);
          checkOutput("f_rdata_hold", bus.f_rdata_o, lastF);
          lastL = monRsp.data;
        end else begin
          checkOutput("f_rdata", bus.f_rdata_o, monRsp.data);
          checkOutput("l_rdata_hold", bus.l_rdata_o, lastL);
          lastF = monRsp.data;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic expL;

    // Reset with both requesters active: no grant, no write strobe.
    bus.f_req_i   = 1'b1;
    bus.f_addr_i  = '0;
    bus.l_req_i   = 1'b1;
    bus.l_we_i    = 1'b1;
    bus.l_addr_i  = 14'h10;
    bus.l_wdata_i = 32'h1234_5678;
    bus.l_lock_i  = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst_f_gnt", bus.f_gnt_o, 1'b0);
    checkOutput("rst_l_gnt", bus.l_gnt_o, 1'b0);
    checkOutput("rst_m_we", bus.m_we_o, 1'b0);
    checkOutput("rst_f_rvalid", bus.f_rvalid_o, 1'b0);
    checkOutput("rst_l_rvalid", bus.l_rvalid_o, 1'b0);
    checkOutput("rst_f_rdata", bus.f_rdata_o, 32'h0);
    checkOutput("rst_l_rdata", bus.l_rdata_o, 32'h0);
    checkOutput("rst_misalign", bus.misalign_o, 1'b0);
    @(negedge clk);
    bus.f_req_i = 1'b0;
    bus.l_req_i = 1'b0;
    bus.l_we_i  = 1'b0;
    bus.l_lock_i = 1'b0;
    rst = 1'b0;

    $display("[TB] fetch-only back-to-back");
    applyStimulus(1'b1, 14'h0, 1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA5A5_0000, 1'b0);
    applyStimulus(1'b1, 14'h4, 1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001, 1'b0);
    applyStimulus(1'b1, 14'h8, 1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA5A5_0002, 1'b0);

    $display("[TB] loader write then reads");
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 14'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    applyStimulus(1'b1, 14'h10, 1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 14'h10, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b1, 14'h14, 1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA5A5_0005, 1'b0);

    $display("[TB] misaligned fetch");
    applyStimulus(1'b1, 14'h13, 1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
    idleCycle();

    $display("[TB] continuous contention");
    for (int c = 1; c <= 18; c++) begin
`ifdef IMEM_ARB_RR_EN
      expL = (c % 2) == 1;
`else
      expL = (c % 9) != 0;
`endif
      applyStimulus(1'b1, 14'h0, 1'b1, 1'b0, 14'h20, 32'h0, 1'b0,
                    !expL, expL, expL ? 32'hA5A5_0008 : 32'hA5A5_0000, 1'b0);
    end
    idleCycle();

    $display("[TB] loader lock against pending fetch");
    for (int c = 1; c <= 10; c++) begin
      expL = (c != 9);
      applyStimulus(1'b1, 14'h4, 1'b1, 1'b0, 14'h24, 32'h0, 1'b1,
                    !expL, expL, expL ? 32'hA5A5_0009 : 32'hA5A5_0001, 1'b0);
    end
`ifdef IMEM_ARB_RR_EN
    expL = 1'b0;
`else
    expL = 1'b1;
`endif
    applyStimulus(1'b1, 14'h4, 1'b1, 1'b0, 14'h24, 32'h0, 1'b0,
                  !expL, expL, expL ? 32'hA5A5_0009 : 32'hA5A5_0001, 1'b0);
    idleCycle();

`ifndef IMEM_ARB_RR_EN
    $display("[TB] starvation count clears when fetch drops");
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1'b1, 14'h0, 1'b1, 1'b0, 14'h20, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0008, 1'b0);
    end
    applyStimulus(1'b0, 14'h0, 1'b1, 1'b0, 14'h20, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0008, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      expL = (c != 9);
      applyStimulus(1'b1, 14'h0, 1'b1, 1'b0, 14'h20, 32'h0, 1'b0,
                    !expL, expL, expL ? 32'hA5A5_0008 : 32'hA5A5_0000, 1'b0);
    end
    idleCycle();
`endif

    $display("[TB] reset during response cycle");
    applyStimulus(1'b1, 14'h4, 1'b0, 1'b0, '0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    bus.f_req_i = 1'b1;
    bus.l_req_i = 1'b1;
    bus.l_we_i  = 1'b1;
    #1;
    checkOutput("midrst_f_rvalid", bus.f_rvalid_o, 1'b0);
    checkOutput("midrst_l_rvalid", bus.l_rvalid_o, 1'b0);
    checkOutput("midrst_f_rdata", bus.f_rdata_o, 32'h0);
    checkOutput("midrst_l_rdata", bus.l_rdata_o, 32'h0);
    checkOutput("midrst_misalign", bus.misalign_o, 1'b0);
    checkOutput("midrst_f_gnt", bus.f_gnt_o, 1'b0);
    checkOutput("midrst_l_gnt", bus.l_gnt_o, 1'b0);
    checkOutput("midrst_m_we", bus.m_we_o, 1'b0);
    @(posedge clk);
    #2;
    bus.f_req_i = 1'b0;
    bus.l_req_i = 1'b0;
    bus.l_we_i  = 1'b0;
    rst = 1'b0;
    repeat (3) idleCycle();

    @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-requester arbiter and sequencer in front of the single-port, combinational-read instruction memory. It shares the memory between the core fetch port and the program loader/debug port, which can read or write. It drives one memory access per cycle, registers the read data, and returns a one-cycle-latency response to the granted requester. It sits between the fetch stage, the loader and the instruction memory.

## Interface
- IMEM_W, 14, byte-address width of the instruction memory (2^IMEM_W bytes)
- STARVE_MAX, 8, consecutive denied fetch cycles before a forced fetch grant (fixed-priority mode only, ≥1)

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- f_req_i  in  1  fetch read request
- f_addr_i  in  IMEM_W  fetch byte address
- f_gnt_o  out  1  fetch request accepted this cycle
- f_rvalid_o  out  1  fetch response valid
- f_rdata_o  out  32  fetch read data
- l_req_i  in  1  loader request
- l_we_i  in  1  loader write (1) or read (0)
- l_addr_i  in  IMEM_W  loader byte address
- l_wdata_i  in  32  loader write data
- l_lock_i  in  1  loader holds the grant while granted and still requesting
- l_gnt_o  out  1  loader request accepted this cycle
- l_rvalid_o  out  1  loader response valid (read data or write ack)
- l_rdata_o  out  32  loader read data (0 for write acks)
- misalign_o  out  1  accompanies rvalid; granted address had addr[1:0]≠0
- m_addr_o  out  IMEM_W  memory byte address, bits [1:0] forced to 0
- m_we_o  out  1  memory write strobe (full word)
- m_wdata_o  out  32  memory write data
- m_rdata_i  in  32  memory combinational read data for m_addr_o

## Operation
- Grant logic is combinational within the request cycle. At most one of f_gnt_o and l_gnt_o is high. No request means no grant, and m_we_o=0.
- The granted requester's address, we and wdata drive the memory port. Fetch is always a read.
- Fixed-priority mode (default): the loader wins ties. Exceptions:
  - The starvation counter counts cycles where f_req_i=1 and fetch is not granted.
  - When the count reaches STARVE_MAX, fetch is granted the next contended cycle and the counter clears.
  - The counter also clears on any fetch grant or when f_req_i=0.
  - The forced fetch grant overrides l_lock_i.
- Lock: if the loader was granted last cycle and l_req_i=l_lock_i=1, the loader is granted again, except when a forced fetch grant applies.
- Response register:
  - On each grant edge, rdata (from m_rdata_i, or 0 for writes), the owner and the misalign bit are captured.
  - Next cycle, the owner's rvalid_o is high for exactly one cycle. The other rdata output holds its previous value.
- Requesters may drop or change requests without a grant. No transaction is remembered.

## Timing
- Grant: 0 cycles (same cycle as request).
- Read response: rvalid_o and rdata_o one cycle after grant. Back-to-back grants yield back-to-back responses. Full throughput is one access per cycle.
- A write commits to memory at the grant edge. A read granted the following cycle at the same address returns the new data.
- Reset values: f_rvalid_o=l_rvalid_o=0, f_rdata_o=l_rdata_o=0, misalign_o=0, starvation counter=0, last-grant=fetch. All grants and m_we_o are 0 while rst_i=1.
- Reset asserted mid-operation drops any pending response immediately (asynchronous). No rvalid appears after rst_i is released.

## Configuration
- IMEM_ARB_RR_EN defined:
  - Arbitration is round-robin. On contention, the requester not granted last is selected.
  - l_lock_i is still honored. The loader can keep the grant at most STARVE_MAX consecutive cycles while fetch is pending.
  - The fixed-priority starvation counter is removed.
- IMEM_ARB_RR_EN undefined: fixed-priority loader-first with the starvation guard, as described above.

## Test plan
- Fetch only, addresses 0x0, 0x4, 0x8 back-to-back → f_gnt_o=1 each cycle; f_rvalid_o=1 in cycles 1–3 with memory words 0–2.
- Loader writes 0xDEADBEEF @0x10, then fetch reads 0x10 next cycle → l_rvalid_o with l_rdata_o=0, then f_rdata_o=0xDEADBEEF.
- Both requesting continuously, STARVE_MAX=8, fixed mode → loader granted 8 cycles, fetch granted on the 9th, repeating. In RR mode, grants alternate.
- Fetch address 0x13 → m_addr_o=0x10; f_rvalid_o and misalign_o high together next cycle.
- Loader lock held with fetch pending → loader keeps the grant until the forced fetch grant at cycle STARVE_MAX+1; l_lock_i dropped → normal arbitration resumes.
- rst_i asserted in the cycle after a grant → rvalid stays 0, outputs return to reset values, and no response follows release.
